// File: rtl/pmem_types_pkg.sv
// Shared types for the pmem responder: line and address types, offset width, FSM states.
package pmem_types_pkg;
  localparam int PMEM_OFFSET_BITS = 4;

  typedef logic [127:0] line_t;
  typedef logic [15:0]  pmem_addr_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;
endpackage

// File: rtl/pmem_line_array.sv
// Synchronous single-port line store: one read or write per enabled cycle, registered read data.
module pmem_line_array
  import pmem_types_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] index,
  input  line_t                 wdata,
  output line_t                 rdata
);
  line_t mem [2**INDEX_BITS];

  // Storage is deliberately left unreset so committed lines survive rst_n.
  always_ff @(posedge clk) begin
    if (en && we) mem[index] <= wdata;
  end

  // Read data only moves on a read, so it holds across writes and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata <= '0;
    else if (en && !we)  rdata <= mem[index];
  end
endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency pmem responder: accepts one line read/write, waits LATENCY edges, pulses pmem_resp.
module pmem_responder
  import pmem_types_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pmem_read,
  input  logic       pmem_write,
  input  pmem_addr_t pmem_address,
  input  line_t      pmem_wdata,
  output logic       pmem_resp,
  output line_t      pmem_rdata,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic       proto_err
);
  // Handshake: a request is taken on any edge in IDLE where pmem_read or
  // pmem_write is high; the requester sees completion as a one-cycle pmem_resp
  // and may present the next request from the cycle after it.
  pmem_state_t           state, state_next;
  logic [7:0]            cnt;
  logic [INDEX_BITS-1:0] idx_q;
  line_t                 wdata_q;
  logic                  op_write;
  logic                  accept, commit;

  logic unused_addr;
  assign unused_addr = ^pmem_address;

  assign accept = (state == IDLE) && (pmem_read || pmem_write);
  assign commit = (state == BUSY) && (cnt == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pmem_read || pmem_write) state_next = BUSY;
      BUSY:    if (cnt == 8'd0)             state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pmem_resp = (state == RESP);
  end

  // Request fields are latched at accept so later input changes cannot disturb the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      idx_q    <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
    end else if (accept) begin
      cnt      <= 8'(LATENCY - 1);
      idx_q    <= pmem_address[PMEM_OFFSET_BITS +: INDEX_BITS];
      wdata_q  <= pmem_wdata;
      op_write <= pmem_write;
    end else if ((state == BUSY) && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
      proto_err <= 1'b0;
    end else begin
      if (accept && pmem_read && pmem_write) proto_err <= 1'b1;
      if (commit && op_write && (wr_count != 16'hFFFF))  wr_count <= wr_count + 16'd1;
      if (commit && !op_write && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
    end
  end

  pmem_line_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit),
    .we    (op_write),
    .index (idx_q),
    .wdata (wdata_q),
    .rdata (pmem_rdata)
  );
endmodule
